// File: rtl/stream_fifo_pkg.sv
// Shared definitions for the stream FIFO: strobe mode codes and width helpers.
// Imported by stream_fifo and stream_fifo_strobe_qualify.
package stream_fifo_pkg;

   localparam int MODE_LEVEL = 0;
   localparam int MODE_EDGE  = 1;

   // Ceiling log2; returns 0 for values of 0 or 1.
   function automatic int clog2(input int value);
      int result;
      int remaining;
      result    = 0;
      remaining = value - 1;
      while (remaining > 0) begin
         result    = result + 1;
         remaining = remaining >> 1;
      end
      return result;
   endfunction

   // The level counter must represent 0..DEPTH inclusive, one bit wider than a pointer.
   function automatic int level_width(input int address_width);
      return address_width + 1;
   endfunction

endpackage

// File: rtl/stream_fifo_strobe_qualify.sv
// Turns a raw bus strobe into a one-cycle request (edge mode) or passes it through (level mode).
// The delayed copy keeps loading during reset, so a strobe held across reset never fires.
module stream_fifo_strobe_qualify
   import stream_fifo_pkg::*;
#(
   parameter int EDGE_MODE = MODE_EDGE
)(
   input  logic clk,
   input  logic reset,
   input  logic strobe,
   output logic req
);

   generate
      if (EDGE_MODE == MODE_EDGE) begin : g_edge
         logic strobe_reg;

         // Load unconditionally, including while reset is high.
         always_ff @(posedge clk) begin
            if (reset) begin
               strobe_reg <= strobe;
            end else begin
               strobe_reg <= strobe;
            end
         end

         assign req = strobe & ~strobe_reg;
      end else begin : g_level
         logic unused_level_mode;
         assign unused_level_mode = &{1'b0, clk, reset};
         assign req = strobe;
      end
   endgenerate

endmodule

// File: rtl/stream_fifo.sv
// Show-ahead synchronous FIFO with edge/level strobes, fill level and almost flags.
// Define STREAM_FIFO_ERR_EN to add sticky overflow/underflow outputs.
module stream_fifo
   import stream_fifo_pkg::*;
#(
   parameter int WORD_SIZE     = 8,
   parameter int ADDRESS_WIDTH = 8,
   parameter int EDGE_MODE     = MODE_EDGE,
   parameter int AF_THRESH     = (1 << ADDRESS_WIDTH) - 4,
   parameter int AE_THRESH     = 4
)(
   input  logic                     clk,
   input  logic                     reset,
   input  logic [WORD_SIZE-1:0]     d,
   input  logic                     write,
   input  logic                     read,
   output logic [WORD_SIZE-1:0]     q,
   output logic                     empty,
   output logic                     full,
   output logic [ADDRESS_WIDTH:0]   level,
   output logic                     almost_full,
   output logic                     almost_empty
`ifdef STREAM_FIFO_ERR_EN
   ,
   output logic                     overflow,
   output logic                     underflow
`endif
);

   localparam int DEPTH = 1 << ADDRESS_WIDTH;
   localparam int LW    = level_width(ADDRESS_WIDTH);

   localparam logic [LW-1:0] DEPTH_LVL = LW'(DEPTH);
   localparam logic [LW-1:0] AF_LVL    = LW'(AF_THRESH);
   localparam logic [LW-1:0] AE_LVL    = LW'(AE_THRESH);

   logic [WORD_SIZE-1:0]     mem [DEPTH];
   logic [ADDRESS_WIDTH-1:0] waddr_reg;
   logic [ADDRESS_WIDTH-1:0] raddr_reg;
   logic [LW-1:0]            level_reg;
   logic [LW-1:0]            level_next;

   logic [1:0] strobe_in;
   logic [1:0] strobe_req;
   logic       wr_req;
   logic       rd_req;
   logic       wr_ok;
   logic       rd_ok;

   // Index 0 carries write, index 1 carries read.
   assign strobe_in = {read, write};

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_qualify
         stream_fifo_strobe_qualify #(
            .EDGE_MODE (EDGE_MODE)
         ) u_qualify (
            .clk    (clk),
            .reset  (reset),
            .strobe (strobe_in[gi]),
            .req    (strobe_req[gi])
         );
      end
   endgenerate

   assign wr_req = strobe_req[0];
   assign rd_req = strobe_req[1];

   // Flags decode the registered level directly.
   assign empty        = (level_reg == '0);
   assign full         = (level_reg == DEPTH_LVL);
   assign almost_full  = (level_reg >= AF_LVL);
   assign almost_empty = (level_reg <= AE_LVL);
   assign level        = level_reg;

   // A read frees a slot in the same cycle, so a full FIFO still takes a paired write.
   // No fall-through: a read against an empty FIFO is dropped even if a write arrives.
   assign rd_ok = rd_req & ~empty;
   assign wr_ok = wr_req & (~full | rd_ok);

   always_comb begin
      level_next = level_reg;
      case ({wr_ok, rd_ok})
         2'b10:   level_next = level_reg + LW'(1);
         2'b01:   level_next = level_reg - LW'(1);
         default: level_next = level_reg;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         waddr_reg <= '0;
         raddr_reg <= '0;
         level_reg <= '0;
      end else begin
         if (wr_ok) begin
            waddr_reg <= waddr_reg + 1'b1;
         end
         if (rd_ok) begin
            raddr_reg <= raddr_reg + 1'b1;
         end
         level_reg <= level_next;
      end
   end

   // Storage is never cleared; reset only blocks the write.
   always_ff @(posedge clk) begin
      if (wr_ok && !reset) begin
         mem[waddr_reg] <= d;
      end
   end

   assign q = mem[raddr_reg];

`ifdef STREAM_FIFO_ERR_EN
   logic overflow_reg;
   logic underflow_reg;

   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_reg  <= 1'b0;
         underflow_reg <= 1'b0;
      end else begin
         if (wr_req && !wr_ok) begin
            overflow_reg <= 1'b1;
         end
         if (rd_req && !rd_ok) begin
            underflow_reg <= 1'b1;
         end
      end
   end

   assign overflow  = overflow_reg;
   assign underflow = underflow_reg;
`endif

endmodule

// File: tb/tb_stream_fifo.sv
// Directed bench for stream_fifo: an edge-mode and a level-mode instance, depth 16.
// Expected values are hand-computed constants in the step sequence below.
module tb_stream_fifo;

   logic       clk;

   // Edge-mode instance
   logic       reset;
   logic [7:0] d;
   logic       write;
   logic       read;
   logic [7:0] q;
   logic       empty;
   logic       full;
   logic [4:0] level;
   logic       almost_full;
   logic       almost_empty;

   // Level-mode instance
   logic       lvl_reset;
   logic [7:0] lvl_d;
   logic       lvl_write;
   logic       lvl_read;
   logic [7:0] lvl_q;
   logic       lvl_empty;
   logic       lvl_full;
   logic [4:0] lvl_level;
   logic       lvl_almost_full;
   logic       lvl_almost_empty;

`ifdef STREAM_FIFO_ERR_EN
   logic overflow;
   logic underflow;
   logic lvl_overflow;
   logic lvl_underflow;
`endif

   int compared   = 0;
   int mismatched = 0;

   stream_fifo #(
      .WORD_SIZE     (8),
      .ADDRESS_WIDTH (4),
      .EDGE_MODE     (1),
      .AF_THRESH     (12),
      .AE_THRESH     (4)
   ) u_edge (
      .clk          (clk),
      .reset        (reset),
      .d            (d),
      .write        (write),
      .read         (read),
      .q            (q),
      .empty        (empty),
      .full         (full),
      .level        (level),
      .almost_full  (almost_full),
      .almost_empty (almost_empty)
`ifdef STREAM_FIFO_ERR_EN
      ,
      .overflow     (overflow),
      .underflow    (underflow)
`endif
   );

   stream_fifo #(
      .WORD_SIZE     (8),
      .ADDRESS_WIDTH (4),
      .EDGE_MODE     (0),
      .AF_THRESH     (12),
      .AE_THRESH     (4)
   ) u_level (
      .clk          (clk),
      .reset        (lvl_reset),
      .d            (lvl_d),
      .write        (lvl_write),
      .read         (lvl_read),
      .q            (lvl_q),
      .empty        (lvl_empty),
      .full         (lvl_full),
      .level        (lvl_level),
      .almost_full  (lvl_almost_full),
      .almost_empty (lvl_almost_empty)
`ifdef STREAM_FIFO_ERR_EN
      ,
      .overflow     (lvl_overflow),
      .underflow    (lvl_underflow)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Advance one clock and sample 1 ns after the rising edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected)
      else begin
         mismatched++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic push(input logic [7:0] value);
      d     = value;
      write = 1'b1;
      tick();
      write = 1'b0;
      tick();
   endtask

   task automatic pop();
      read = 1'b1;
      tick();
      read = 1'b0;
      tick();
   endtask

   initial begin
      reset = 1'b1; d = 8'h00; write = 1'b0; read = 1'b0;
      lvl_reset = 1'b1; lvl_d = 8'h00; lvl_write = 1'b0; lvl_read = 1'b0;
      tick();
      tick();
      reset = 1'b0;
      lvl_reset = 1'b0;

      // Reset state
      check("rst_level", 32'(level), 32'd0);
      check("rst_empty", 32'(empty), 32'd1);
      check("rst_full", 32'(full), 32'd0);
      check("rst_almost_empty", 32'(almost_empty), 32'd1);
      check("rst_almost_full", 32'(almost_full), 32'd0);
`ifdef STREAM_FIFO_ERR_EN
      check("rst_overflow", 32'(overflow), 32'd0);
      check("rst_underflow", 32'(underflow), 32'd0);
`endif

      // 1: three edge writes, show-ahead head, then three reads
      push(8'h11);
      check("t1_first_q", 32'(q), 32'h11);
      push(8'h22);
      push(8'h33);
      check("t1_level", 32'(level), 32'd3);
      check("t1_q", 32'(q), 32'h11);
      check("t1_empty", 32'(empty), 32'd0);
      pop();
      check("t1_q_after_pop1", 32'(q), 32'h22);
      pop();
      check("t1_q_after_pop2", 32'(q), 32'h33);
      pop();
      check("t1_empty_after", 32'(empty), 32'd1);
      check("t1_level_after", 32'(level), 32'd0);

      // 2: fill with 0..15, watch almost_full, then a dropped write
      for (int i = 0; i < 16; i++) begin
         push(8'(i));
         if (i == 4) begin
            check("t2_almost_empty_at5", 32'(almost_empty), 32'd0);
         end
         if (i == 10) begin
            check("t2_almost_full_at11", 32'(almost_full), 32'd0);
         end
         if (i == 11) begin
            check("t2_almost_full_at12", 32'(almost_full), 32'd1);
         end
      end
      check("t2_full", 32'(full), 32'd1);
      check("t2_level", 32'(level), 32'd16);
      push(8'hAA);
      check("t2_level_after_drop", 32'(level), 32'd16);
      check("t2_q_after_drop", 32'(q), 32'h00);
`ifdef STREAM_FIFO_ERR_EN
      check("t2_overflow", 32'(overflow), 32'd1);
`endif

      // 3: full with simultaneous write 0x55 and read
      d = 8'h55; write = 1'b1; read = 1'b1;
      tick();
      write = 1'b0; read = 1'b0;
      tick();
      check("t3_level", 32'(level), 32'd16);
      check("t3_q", 32'(q), 32'h01);
      for (int i = 1; i < 16; i++) begin
         check($sformatf("t3_drain_%0d", i), 32'(q), 32'(i));
         pop();
      end
      check("t3_last_word", 32'(q), 32'h55);
      check("t3_level_one", 32'(level), 32'd1);
      pop();
      check("t3_empty", 32'(empty), 32'd1);

      // 4: empty with simultaneous write 0x77 and read
      d = 8'h77; write = 1'b1; read = 1'b1;
      tick();
      write = 1'b0; read = 1'b0;
      tick();
      check("t4_level", 32'(level), 32'd1);
      check("t4_q", 32'(q), 32'h77);
      check("t4_empty", 32'(empty), 32'd0);
`ifdef STREAM_FIFO_ERR_EN
      check("t4_underflow", 32'(underflow), 32'd1);
`endif
      pop();
      check("t4_drained", 32'(level), 32'd0);

      // 6: reset at level 9 with write held high
      for (int i = 0; i < 9; i++) begin
         push(8'(8'h40 + i));
      end
      check("t6_level_before", 32'(level), 32'd9);
      d = 8'hEE; write = 1'b1; reset = 1'b1;
      tick();
      check("t6_level_in_reset", 32'(level), 32'd0);
      check("t6_empty_in_reset", 32'(empty), 32'd1);
      reset = 1'b0;
      tick();
      check("t6_no_write_after_reset", 32'(level), 32'd0);
      check("t6_empty_after_reset", 32'(empty), 32'd1);
`ifdef STREAM_FIFO_ERR_EN
      check("t6_overflow_cleared", 32'(overflow), 32'd0);
      check("t6_underflow_cleared", 32'(underflow), 32'd0);
`endif
      write = 1'b0;
      tick();

      // 5: write held five clocks, level mode versus edge mode
      lvl_write = 1'b1;
      write     = 1'b1;
      for (int i = 0; i < 5; i++) begin
         lvl_d = 8'(8'hA0 + i);
         d     = 8'(8'hB0 + i);
         tick();
      end
      lvl_write = 1'b0;
      write     = 1'b0;
      tick();
      check("t5_level_mode_level", 32'(lvl_level), 32'd5);
      check("t5_level_mode_q", 32'(lvl_q), 32'hA0);
      check("t5_edge_mode_level", 32'(level), 32'd1);
      check("t5_edge_mode_q", 32'(q), 32'hB0);
      lvl_read = 1'b1;
      tick();
      tick();
      lvl_read = 1'b0;
      tick();
      check("t5_level_mode_read2", 32'(lvl_level), 32'd3);
      check("t5_level_mode_q2", 32'(lvl_q), 32'hA2);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
